// File: rtl/cnn_acc_pkg.sv
// Shared types and lane arithmetic for the CNN output accumulator.
// Lane defaults follow the array geometry defines.
`ifndef Tout
`define Tout 32
`endif
`ifndef MAX_DW2
`define MAX_DW2 16
`endif
`ifndef base_log2Tin
`define base_log2Tin 4
`endif

package cnn_acc_pkg;

  localparam int TOUT_DEF   = `Tout;
  localparam int IN_DW_DEF  = `MAX_DW2 + `base_log2Tin;
  localparam int ACC_DW_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  // Sign-extend both operands from their lane widths, add, clamp to acc_w.
  function automatic logic [63:0] lane_acc(
    input logic [63:0] acc,
    input logic [63:0] din,
    input int          acc_w,
    input int          in_w
  );
    logic signed [63:0] a;
    logic signed [63:0] d;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    a  = $signed(acc << (64 - acc_w)) >>> (64 - acc_w);
    d  = $signed(din << (64 - in_w)) >>> (64 - in_w);
    s  = a + d;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (acc_w - 1));
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/column_systolic_acc_ram.sv
// Per-Wout-position accumulation buffer.
// Simple dual port, registered read, contents never reset.
module acc_buf_ram #(
  parameter int DEPTH = 64,
  parameter int DW    = 1024,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/column_systolic_acc.sv
// Multi-pass output accumulator behind the column systolic MAC array.
// Two-stage read/add/write-back pipeline with same-address forwarding.
module column_systolic_acc
  import cnn_acc_pkg::*;
#(
  parameter int TOUT     = TOUT_DEF,
  parameter int IN_DW    = IN_DW_DEF,
  parameter int ACC_DW   = ACC_DW_DEF,
  parameter int WOUT_MAX = 64,
  parameter int AW       = $clog2(WOUT_MAX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW:0]          cfg_wout,
  input  logic [15:0]          cfg_passes,
  input  logic                 in_vld,
  input  logic [TOUT*IN_DW-1:0]  in_dat,
  output logic                 out_vld,
  output logic [TOUT*ACC_DW-1:0] out_dat,
  output logic [AW-1:0]        out_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int IW = TOUT * IN_DW;
  localparam int DW = TOUT * ACC_DW;

  state_t state_q, state_d;
  logic   drain_q;

  logic [AW:0]   wout_q;
  logic [15:0]   passes_q;
  logic [AW-1:0] pos_q;
  logic [15:0]   pass_q;

  logic accept, pos_last, pass_last;
  logic start_ok, cfg_ok, go, set_err;

  logic          s1_vld, s1_first, s1_last;
  logic [AW-1:0] s1_addr;
  logic [IW-1:0] s1_dat;
  logic          s2_vld;
  logic [AW-1:0] s2_addr;
  logic [DW-1:0] s2_sum;
  logic [DW-1:0] rd_dat;
  logic [DW-1:0] sum;
  logic          fwd;

  assign accept    = (state_q == S_RUN) && in_vld;
  assign pos_last  = ({1'b0, pos_q} == wout_q - (AW+1)'(1));
  assign pass_last = (pass_q == passes_q - 16'd1);

  // The final drain cycle is IDLE-bound, so a start there is legal.
  assign start_ok = (state_q == S_IDLE) ||
                    ((state_q == S_DRAIN) && drain_q);
  assign cfg_ok   = (cfg_wout != '0) &&
                    (cfg_wout <= (AW+1)'(WOUT_MAX)) &&
                    (cfg_passes != 16'd0);
  assign go       = start && start_ok && cfg_ok;
  assign set_err  = (in_vld && (state_q != S_RUN)) ||
                    (start && !start_ok) ||
                    (start && start_ok && !cfg_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_RUN;
      S_RUN:   if (accept && pos_last && pass_last) state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = go ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DRAIN) && drain_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q  <= 1'b0;
      wout_q   <= '0;
      passes_q <= '0;
      pos_q    <= '0;
      pass_q   <= '0;
      err      <= 1'b0;
    end else begin
      drain_q <= (state_q == S_DRAIN) ? !drain_q : 1'b0;
      err     <= (go ? 1'b0 : err) | set_err;
      if (go) begin
        wout_q   <= cfg_wout;
        passes_q <= cfg_passes;
        pos_q    <= '0;
        pass_q   <= '0;
      end else if (accept) begin
        if (pos_last) begin
          pos_q  <= '0;
          pass_q <= pass_q + 16'd1;
        end else begin
          pos_q <= pos_q + AW'(1);
        end
      end
    end
  end

  acc_buf_ram #(
    .DEPTH (WOUT_MAX),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (s1_vld),
    .wr_addr (s1_addr),
    .wr_dat  (sum),
    .rd_en   (accept),
    .rd_addr (pos_q),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      s1_dat   <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_first <= (pass_q == 16'd0);
        s1_last  <= pass_last;
        s1_addr  <= pos_q;
        s1_dat   <= in_dat;
      end
    end
  end

  // s2 was written on the edge that issued s1's read: RAM data is stale.
  assign fwd = s2_vld && (s2_addr == s1_addr);

  for (genvar i = 0; i < TOUT; i++) begin : g_lane
    logic [ACC_DW-1:0] base;
    assign base = s1_first ? '0 :
                  fwd      ? s2_sum[i*ACC_DW +: ACC_DW] :
                             rd_dat[i*ACC_DW +: ACC_DW];
    assign sum[i*ACC_DW +: ACC_DW] = ACC_DW'(lane_acc(
      64'(base), 64'(s1_dat[i*IN_DW +: IN_DW]), ACC_DW, IN_DW));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_addr <= '0;
      s2_sum  <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
      out_idx <= '0;
    end else begin
      s2_vld  <= s1_vld;
      out_vld <= s1_vld && s1_last;
      if (s1_vld) begin
        s2_addr <= s1_addr;
        s2_sum  <= sum;
      end
      if (s1_vld && s1_last) begin
        out_dat <= sum;
        out_idx <= s1_addr;
      end
    end
  end

endmodule

// File: tb/tb_column_systolic_acc.sv
// Directed bench for column_systolic_acc: tile table plus
// bubble, error and mid-tile reset sequences.
module tb_column_systolic_acc;

  localparam int TOUT   = 8;
  localparam int IN_DW  = 20;
  localparam int ACC_DW = 24;
  localparam int WMAX   = 64;
  localparam int AW     = 6;
  localparam int IW     = TOUT * IN_DW;
  localparam int DW     = TOUT * ACC_DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   cfg_wout = '0;
  logic [15:0]   cfg_passes = '0;
  logic          in_vld = 1'b0;
  logic [IW-1:0] in_dat = '0;
  logic          out_vld;
  logic [DW-1:0] out_dat;
  logic [AW-1:0] out_idx;
  logic          busy, done, err;

  column_systolic_acc #(
    .TOUT     (TOUT),
    .IN_DW    (IN_DW),
    .ACC_DW   (ACC_DW),
    .WOUT_MAX (WMAX),
    .AW       (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_wout   (cfg_wout),
    .cfg_passes (cfg_passes),
    .in_vld     (in_vld),
    .in_dat     (in_dat),
    .out_vld    (out_vld),
    .out_dat    (out_dat),
    .out_idx    (out_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            idx;
    logic [DW-1:0] dat;
    int            cyc;
  } ob_t;

  ob_t ob_tmp;
  ob_t oq[$];
  int  done_cnt = 0;

  always @(negedge clk) begin
    if (out_vld) begin
      ob_tmp.idx = int'(out_idx);
      ob_tmp.dat = out_dat;
      ob_tmp.cyc = cyc;
      oq.push_back(ob_tmp);
    end
    if (done) done_cnt++;
  end

  typedef struct {
    int wout;
    int passes;
    int va;
    int vb;
    int gap;
    int ea;
    int eb;
  } vec_t;

  vec_t tv[6];
  int   n_tot = 0;
  int   n_pass = 0;
  int   mdl[WMAX][TOUT];

  task automatic chk_i(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic chk_v(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [IW-1:0] mk_in(input int a, input int b);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < TOUT; i++) r[i*IN_DW +: IN_DW] = IN_DW'(a + b * i);
    return r;
  endfunction

  function automatic logic [DW-1:0] mk_acc(input int a, input int b);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < TOUT; i++) r[i*ACC_DW +: ACC_DW] = ACC_DW'(a + b * i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input int w, input int p);
    start = 1'b1;
    cfg_wout = (AW+1)'(w);
    cfg_passes = 16'(p);
    tick();
    start = 1'b0;
  endtask

  task automatic check_outs(input string nm, input int w,
                            input logic [DW-1:0] exp);
    chk_i({nm, "_count"}, oq.size(), w);
    for (int k = 0; k < oq.size(); k++) begin
      chk_i({nm, "_idx"}, oq[k].idx, k);
      chk_v({nm, "_dat"}, oq[k].dat, exp);
    end
    chk_i({nm, "_done"}, done_cnt, 1);
    chk_i({nm, "_busy_end"}, int'(busy), 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int flc;
    flc = -1;
    oq.delete();
    done_cnt = 0;
    start_tile(v.wout, v.passes);
    chk_i({nm, "_busy"}, int'(busy), 1);
    for (int p = 0; p < v.passes; p++) begin
      for (int w = 0; w < v.wout; w++) begin
        while (int'($urandom_range(99, 0)) < v.gap) tick();
        in_vld = 1'b1;
        in_dat = mk_in(v.va, v.vb);
        if (p == v.passes - 1 && w == 0) flc = cyc;
        tick();
        in_vld = 1'b0;
      end
    end
    repeat (4) tick();
    if (oq.size() > 0) chk_i({nm, "_lat"}, oq[0].cyc, flc + 2);
    check_outs(nm, v.wout, mk_acc(v.ea, v.eb));
  endtask

  task automatic run_bubbles();
    logic [IW-1:0] x;
    logic [DW-1:0] e;
    int            d;
    oq.delete();
    done_cnt = 0;
    start_tile(64, 2);
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 64; w++) begin
        while (int'($urandom_range(99, 0)) < 35) tick();
        for (int l = 0; l < TOUT; l++) begin
          d = int'($urandom_range(2000, 0)) - 1000;
          x[l*IN_DW +: IN_DW] = IN_DW'(d);
          mdl[w][l] = (p == 0) ? d : mdl[w][l] + d;
        end
        in_vld = 1'b1;
        in_dat = x;
        tick();
        in_vld = 1'b0;
      end
    end
    repeat (4) tick();
    chk_i("bub_count", oq.size(), 64);
    for (int k = 0; k < oq.size(); k++) begin
      for (int l = 0; l < TOUT; l++) e[l*ACC_DW +: ACC_DW] = ACC_DW'(mdl[k][l]);
      chk_i("bub_idx", oq[k].idx, k);
      chk_v("bub_dat", oq[k].dat, e);
    end
    chk_i("bub_done", done_cnt, 1);
  endtask

  task automatic run_errors();
    in_vld = 1'b1;
    in_dat = mk_in(9, 0);
    tick();
    in_vld = 1'b0;
    chk_i("err_idle_vld", int'(err), 1);
    oq.delete();
    done_cnt = 0;
    start_tile(2, 2);
    chk_i("err_clr", int'(err), 0);
    for (int b = 0; b < 4; b++) begin
      in_vld = 1'b1;
      in_dat = mk_in(4, 1);
      if (b == 2) begin
        start = 1'b1;
        cfg_wout = 7'd3;
        cfg_passes = 16'd3;
      end
      tick();
      start = 1'b0;
      in_vld = 1'b0;
      if (b == 2) chk_i("err_run_start", int'(err), 1);
    end
    repeat (4) tick();
    check_outs("err_tile", 2, mk_acc(8, 2));
    start_tile(2, 0);
    chk_i("err_pass0", int'(err), 1);
    chk_i("err_pass0_busy", int'(busy), 0);
    oq.delete();
    done_cnt = 0;
    start_tile(1, 1);
    chk_i("err_clr2", int'(err), 0);
    in_vld = 1'b1;
    in_dat = mk_in(6, 0);
    tick();
    in_vld = 1'b0;
    repeat (4) tick();
    check_outs("err_next", 1, mk_acc(6, 0));
  endtask

  task automatic run_reset();
    vec_t v;
    start_tile(3, 3);
    for (int b = 0; b < 4; b++) begin
      in_vld = 1'b1;
      in_dat = mk_in(7, 3);
      start = (b == 1);
      tick();
      start = 1'b0;
    end
    in_vld = 1'b0;
    chk_i("rst_pre_err", int'(err), 1);
    #2 rst = 1'b1;
    #1;
    chk_i("rst_vld", int'(out_vld), 0);
    chk_v("rst_dat", out_dat, '0);
    chk_i("rst_idx", int'(out_idx), 0);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_done", int'(done), 0);
    chk_i("rst_err", int'(err), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    v = '{3, 2, 5, 1, 0, 10, 2};
    run_vec(v, "rst_new");
  endtask

  initial begin
    tv[0] = '{4, 3, 1, 0, 0, 3, 0};
    tv[1] = '{1, 5, -10, 1, 0, -50, 5};
    tv[2] = '{1, 400, 524287, 0, 0, 8388607, 0};
    tv[3] = '{2, 400, -524288, 0, 0, -8388608, 0};
    tv[4] = '{64, 1, 3, -2, 30, 3, -2};
    tv[5] = '{3, 2, 100, 1000, 0, 200, 2000};

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_i("reset_vld", int'(out_vld), 0);
    chk_v("reset_dat", out_dat, '0);
    chk_i("reset_busy", int'(busy), 0);
    chk_i("reset_done", int'(done), 0);
    chk_i("reset_err", int'(err), 0);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) run_vec(tv[t], $sformatf("vec%0d", t));
    run_bubbles();
    run_errors();
    run_reset();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
